pic_priority_resolver: RTL and testbench
========================================

# pic_priority_resolver

Interrupt request, in-service and priority-resolution stage of the PIC. It latches IR inputs into the IRR, applies the IMR, and resolves the highest pending level under fixed or rotating priority. It raises INT and tracks the two-pulse INTA sequence, maintaining the ISR and executing OCW2 EOI and rotate commands. It drives the one-hot highest-priority vector consumed by the cascade module's IRR input; that vector is held stable across the whole acknowledge sequence.

## Interface
- No parameters; fixed 8 levels.
- CLK  in  1  block clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IR  in  8  interrupt request pins, synchronous to CLK.
- LTIM  in  1  1 = level-triggered, 0 = edge-triggered (ICW1).
- IMR  in  8  mask register (OCW1); 1 = masked.
- AEOI  in  1  automatic EOI on second INTA trailing edge (ICW4).
- AUTO_ROTATE  in  1  rotate on automatic EOI (OCW2 R=1,SL=0,EOI=0 latched in control logic).
- INIT  in  1  one-cycle pulse on ICW1 write.
- OCW2_WR  in  1  one-cycle pulse: OCW2 valid.
- OCW2  in  8  [7]=R, [6]=SL, [5]=EOI, [2:0]=L.
- INTA  in  1  interrupt acknowledge, active-low, synchronous to CLK.
- INT  out  1  interrupt request to CPU.
- HIGHEST  out  8  one-hot level being acknowledged; 0 when none.
- IRR_OUT, ISR_OUT  out  8  register read-back.
- SPURIOUS  out  1  current acknowledge found no pending request.

## Operation
- Priority: register LP[2:0] = lowest-priority level; order is LP+1, LP+2 … LP (mod-8 wrap). Reset/INIT: LP=7 (IR0 highest).
- IRR, edge mode: bit set when IR[i] sampled 0 then 1; cleared when IR[i] sampled 0 or when acknowledged. Level mode: IRR bit = sampled IR[i], except bit cleared on acknowledge cycle.
- Pending = IRR & ~IMR. INT requested when highest pending level has strictly higher priority than highest ISR level (or ISR empty).
- States: IDLE, ACK1 (first INTA low), GAP, ACK2 (second INTA low). INTA fall: IDLE→ACK1, GAP→ACK2. INTA rise: ACK1→GAP, ACK2→IDLE.
- IDLE→ACK1: if pending≠0, HIGHEST ← one-hot of winner, ISR bit set, IRR bit cleared, INT deasserted, SPURIOUS=0. If pending=0: HIGHEST ← 8'h80 (IR7), ISR unchanged, SPURIOUS=1.
- HIGHEST and SPURIOUS frozen ACK1 through ACK2; cleared to 0 on ACK2→IDLE.
- ACK2→IDLE with AEOI=1 and SPURIOUS=0: clear acknowledged ISR bit; if AUTO_ROTATE=1, LP ← that level.
- OCW2 (R,SL,EOI): 001 non-specific EOI clears highest-priority ISR bit; 011 specific EOI clears ISR[L]; 101 non-specific EOI and LP ← cleared level; 111 clear ISR[L], LP ← L; 110 LP ← L; 000/010/100 no action here. Non-specific EOI with ISR=0: no change, LP unchanged.
- OCW2 commands apply in any state; HIGHEST stays frozen.
- INIT or RST: IRR, ISR, edge history ← 0; LP ← 7; state IDLE; all outputs 0. Reset mid-sequence abandons it.

## Timing
- IR, INTA sampled once per CLK; edges detected against previous sample (1-cycle detect latency).
- IR rise on cycle n → IRR set at edge n+1 → INT (registered) high at edge n+2.
- INTA fall sampled at edge k → HIGHEST, ISR, IRR, INT updated at edge k+1.
- OCW2_WR at edge k → ISR/LP updated at edge k; INT re-evaluated at edge k+1.
- Simultaneous acknowledge and EOI in same cycle: acknowledge set applied, then EOI evaluated on pre-set ISR.
- INTA glitch back in IDLE on rise: ignored.

## Structure
- Package pic_pkg: state enum, OCW2 command codes, width constant 8.
- Sub-module pic_rot_encoder: combinational rotating priority encoder (vector, LP → valid, level[2:0]); instantiated twice (pending, ISR).

## Test plan
- Reset: RST high mid-ACK1 → all outputs 0, LP=7; after release IR=8'h04 gives INT two cycles later.
- Fixed priority: IR=8'h24, two INTA pulses → HIGHEST=8'h04, ISR=8'h04; INT reasserts only after EOI (OCW2=8'h20), then HIGHEST=8'h20.
- Rotation: LP=7, ISR=8'h01, OCW2=8'hA0 → ISR=0, LP=0; IR=8'h81 → IR7 wins.
- Set priority: OCW2=8'hC3, IR=8'h11 → HIGHEST=8'h10.
- Spurious: INTA pulses with IRR=0 → HIGHEST=8'h80, SPURIOUS=1, ISR stays 0.
- AEOI + level mode: LTIM=1, AEOI=1, IR=8'h02 held → ISR clears at second INTA rise, INT reasserts two cycles later.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC request / in-service / priority stage.
package pic_pkg;

  localparam int NUM_LEVELS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } ack_state_t;

  // OCW2 {R, SL, EOI}
  typedef enum logic [2:0] {
    OCW2_NOP0       = 3'b000,
    OCW2_NS_EOI     = 3'b001,
    OCW2_NOP2       = 3'b010,
    OCW2_SP_EOI     = 3'b011,
    OCW2_NOP4       = 3'b100,
    OCW2_ROT_NS_EOI = 3'b101,
    OCW2_SET_PRI    = 3'b110,
    OCW2_ROT_SP_EOI = 3'b111
  } ocw2_cmd_t;

  // 0 = highest priority, 7 = lowest (the level held in LP)
  function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lp);
    return level - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver_if.sv
// Control/status bundle between the PIC control logic and the priority resolver.
interface pic_priority_resolver_if;
  import pic_pkg::*;

  logic [NUM_LEVELS-1:0] ir;
  logic                  ltim;
  logic [NUM_LEVELS-1:0] imr;
  logic                  aeoi;
  logic                  auto_rotate;
  logic                  init;
  logic                  ocw2_wr;
  logic [7:0]            ocw2;
  logic                  inta;
  logic                  intr;
  logic [NUM_LEVELS-1:0] highest;
  logic [NUM_LEVELS-1:0] irr_out;
  logic [NUM_LEVELS-1:0] isr_out;
  logic                  spurious;

  modport master (
    output ir, ltim, imr, aeoi, auto_rotate, init, ocw2_wr, ocw2, inta,
    input  intr, highest, irr_out, isr_out, spurious
  );

  modport slave (
    input  ir, ltim, imr, aeoi, auto_rotate, init, ocw2_wr, ocw2, inta,
    output intr, highest, irr_out, isr_out, spurious
  );

endinterface

// File: rtl/pic_rot_encoder.sv
// Rotating priority encoder: finds the highest-priority set bit, scanning LP+1 .. LP.
module pic_rot_encoder
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] vec,
  input  logic [2:0]            lp,
  output logic                  valid,
  output logic [2:0]            level
);

  // Scan lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    for (int i = NUM_LEVELS; i >= 1; i--) begin
      if (vec[lp + 3'(i)]) begin
        valid = 1'b1;
        level = lp + 3'(i);
      end
    end
  end

endmodule

// File: rtl/pic_priority_resolver.sv
// PIC request latch, in-service tracking, priority resolution and INTA sequencing.
//   state   | meaning
//   IDLE    | no acknowledge in progress
//   ACK1    | first INTA low; winner latched into HIGHEST/ISR
//   GAP     | between the two INTA pulses
//   ACK2    | second INTA low; AEOI applied on its trailing edge
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  pic_priority_resolver_if.slave bus
);

  ack_state_t            state, state_nxt;
  logic [NUM_LEVELS-1:0] irr, isr, ir_q, highest;
  logic [NUM_LEVELS-1:0] pending, irr_in, irr_nxt, isr_nxt, ack_set, eoi_clr;
  logic [2:0]            lp, lp_nxt, ack_level, pend_level, isr_level, ocw_l;
  logic                  pend_valid, isr_valid, int_req;
  logic                  intr, spurious;
  logic                  inta_s, inta_d, inta_fall, inta_rise;
  logic                  ack_start, ack_end;
  ocw2_cmd_t             cmd;
  logic                  ocw2_unused;

  assign pending     = irr & ~bus.imr;
  assign inta_fall   = inta_d & ~inta_s;
  assign inta_rise   = ~inta_d & inta_s;
  assign cmd         = ocw2_cmd_t'(bus.ocw2[7:5]);
  assign ocw_l       = bus.ocw2[2:0];
  assign ocw2_unused = ^bus.ocw2[4:3];

  pic_rot_encoder u_pend_enc (.vec(pending), .lp(lp), .valid(pend_valid), .level(pend_level));
  pic_rot_encoder u_isr_enc  (.vec(isr),     .lp(lp), .valid(isr_valid),  .level(isr_level));

  assign int_req = pend_valid &&
                   (!isr_valid || (prio_rank(pend_level, lp) < prio_rank(isr_level, lp)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           state <= ST_IDLE;
    else if (bus.init) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_start = 1'b0;
    ack_end   = 1'b0;
    case (state)
      ST_IDLE: if (inta_fall) begin
        state_nxt = ST_ACK1;
        ack_start = 1'b1;
      end
      ST_ACK1: if (inta_rise) state_nxt = ST_GAP;
      ST_GAP:  if (inta_fall) state_nxt = ST_ACK2;
      ST_ACK2: if (inta_rise) begin
        state_nxt = ST_IDLE;
        ack_end   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // EOI targets come from the registered ISR, so an acknowledge in the same
  // cycle is set first and never hides the level the EOI refers to.
  always_comb begin
    ack_set = '0;
    eoi_clr = '0;
    lp_nxt  = lp;
    if (ack_start && pend_valid) ack_set = 8'd1 << pend_level;
    if (ack_end && bus.aeoi && !spurious) begin
      eoi_clr = highest;
      if (bus.auto_rotate) lp_nxt = ack_level;
    end
    if (bus.ocw2_wr) begin
      case (cmd)
        OCW2_NS_EOI:     if (isr_valid) eoi_clr = eoi_clr | (8'd1 << isr_level);
        OCW2_SP_EOI:     eoi_clr = eoi_clr | (8'd1 << ocw_l);
        OCW2_ROT_NS_EOI: if (isr_valid) begin
          eoi_clr = eoi_clr | (8'd1 << isr_level);
          lp_nxt  = isr_level;
        end
        OCW2_ROT_SP_EOI: begin
          eoi_clr = eoi_clr | (8'd1 << ocw_l);
          lp_nxt  = ocw_l;
        end
        OCW2_SET_PRI:    lp_nxt = ocw_l;
        default:         ;
      endcase
    end
  end

  always_comb begin
    irr_in  = bus.ltim ? bus.ir : (bus.ir & (irr | ~ir_q));
    irr_nxt = irr_in & ~ack_set;
    isr_nxt = (isr | ack_set) & ~eoi_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr       <= '0;
      isr       <= '0;
      ir_q      <= '0;
      lp        <= 3'd7;
      intr      <= 1'b0;
      highest   <= '0;
      spurious  <= 1'b0;
      ack_level <= 3'd0;
      inta_s    <= 1'b1;
      inta_d    <= 1'b1;
    end else begin
      inta_s <= bus.inta;
      inta_d <= inta_s;
      if (bus.init) begin
        irr       <= '0;
        isr       <= '0;
        ir_q      <= '0;
        lp        <= 3'd7;
        intr      <= 1'b0;
        highest   <= '0;
        spurious  <= 1'b0;
        ack_level <= 3'd0;
      end else begin
        ir_q <= bus.ir;
        irr  <= irr_nxt;
        isr  <= isr_nxt;
        lp   <= lp_nxt;
        intr <= ack_start ? 1'b0 : int_req;
        if (ack_start) begin
          highest   <= pend_valid ? (8'd1 << pend_level) : 8'h80;
          spurious  <= !pend_valid;
          ack_level <= pend_valid ? pend_level : 3'd7;
        end else if (ack_end) begin
          highest  <= '0;
          spurious <= 1'b0;
        end
      end
    end
  end

  assign bus.intr     = intr;
  assign bus.highest  = highest;
  assign bus.irr_out  = irr;
  assign bus.isr_out  = isr;
  assign bus.spurious = spurious;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver with hand-computed expectations.
module tb_pic_priority_resolver;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pic_priority_resolver_if bus_if ();

  pic_priority_resolver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic inta_low();
    bus_if.inta = 1'b0;
    tick(2);
  endtask

  task automatic inta_high();
    bus_if.inta = 1'b1;
    tick(2);
  endtask

  task automatic ocw2_write(input logic [7:0] val);
    bus_if.ocw2    = val;
    bus_if.ocw2_wr = 1'b1;
    tick(1);
    bus_if.ocw2_wr = 1'b0;
  endtask

  task automatic init_pulse();
    bus_if.init = 1'b1;
    tick(1);
    bus_if.init = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                = 1'b1;
    bus_if.ir          = 8'h00;
    bus_if.ltim        = 1'b0;
    bus_if.imr         = 8'h00;
    bus_if.aeoi        = 1'b0;
    bus_if.auto_rotate = 1'b0;
    bus_if.init        = 1'b0;
    bus_if.ocw2_wr     = 1'b0;
    bus_if.ocw2        = 8'h00;
    bus_if.inta        = 1'b1;
    tick(3);
    check_val("rst_int", 8'(bus_if.intr), 8'h00);
    check_val("rst_highest", bus_if.highest, 8'h00);
    check_val("rst_irr", bus_if.irr_out, 8'h00);
    check_val("rst_isr", bus_if.isr_out, 8'h00);
    check_val("rst_spur", 8'(bus_if.spurious), 8'h00);
    rst = 1'b0;

    // Reset mid-ACK1, with LP moved away from 7 beforehand
    ocw2_write(8'hC2);
    bus_if.ir = 8'h08;
    tick(2);
    check_val("r_irr", bus_if.irr_out, 8'h08);
    check_val("r_int", 8'(bus_if.intr), 8'h01);
    inta_low();
    check_val("r_ack_highest", bus_if.highest, 8'h08);
    check_val("r_ack_isr", bus_if.isr_out, 8'h08);
    check_val("r_ack_int", 8'(bus_if.intr), 8'h00);
    rst = 1'b1;
    #2;
    check_val("r_mid_highest", bus_if.highest, 8'h00);
    check_val("r_mid_isr", bus_if.isr_out, 8'h00);
    check_val("r_mid_irr", bus_if.irr_out, 8'h00);
    tick(1);
    rst = 1'b0;
    bus_if.inta = 1'b1;
    bus_if.ir   = 8'h04;
    tick(1);
    check_val("r_post_irr", bus_if.irr_out, 8'h04);
    check_val("r_post_int0", 8'(bus_if.intr), 8'h00);
    tick(1);
    check_val("r_post_int1", 8'(bus_if.intr), 8'h01);
    bus_if.ir = 8'h00;
    init_pulse();
    check_val("init_irr", bus_if.irr_out, 8'h00);
    check_val("init_int", 8'(bus_if.intr), 8'h00);

    // Fixed priority: IR2 beats IR5 (also shows LP back at 7)
    bus_if.ir = 8'h24;
    tick(2);
    check_val("fp_int", 8'(bus_if.intr), 8'h01);
    inta_low();
    check_val("fp_highest", bus_if.highest, 8'h04);
    check_val("fp_isr", bus_if.isr_out, 8'h04);
    check_val("fp_irr", bus_if.irr_out, 8'h20);
    check_val("fp_spur", 8'(bus_if.spurious), 8'h00);
    inta_high();
    check_val("fp_gap_int", 8'(bus_if.intr), 8'h00);
    inta_low();
    check_val("fp_ack2_highest", bus_if.highest, 8'h04);
    inta_high();
    check_val("fp_end_highest", bus_if.highest, 8'h00);
    check_val("fp_end_isr", bus_if.isr_out, 8'h04);
    check_val("fp_end_int", 8'(bus_if.intr), 8'h00);
    ocw2_write(8'h20);
    check_val("fp_eoi_isr", bus_if.isr_out, 8'h00);
    tick(1);
    check_val("fp_eoi_int", 8'(bus_if.intr), 8'h01);
    inta_low();
    check_val("fp2_highest", bus_if.highest, 8'h20);
    check_val("fp2_isr", bus_if.isr_out, 8'h20);
    check_val("fp2_irr", bus_if.irr_out, 8'h00);
    inta_high();
    inta_low();
    inta_high();
    ocw2_write(8'h20);
    check_val("fp2_eoi_isr", bus_if.isr_out, 8'h00);

    // Rotation via rotate-on-non-specific-EOI
    bus_if.ir = 8'h00;
    tick(1);
    bus_if.ir = 8'h01;
    tick(2);
    inta_low();
    inta_high();
    inta_low();
    inta_high();
    check_val("rot_isr", bus_if.isr_out, 8'h01);
    ocw2_write(8'hA0);
    check_val("rot_eoi_isr", bus_if.isr_out, 8'h00);
    bus_if.ir = 8'h00;
    tick(1);
    bus_if.ir = 8'h81;
    tick(2);
    check_val("rot_irr", bus_if.irr_out, 8'h81);
    check_val("rot_int", 8'(bus_if.intr), 8'h01);
    inta_low();
    check_val("rot_highest", bus_if.highest, 8'h80);
    check_val("rot_isr7", bus_if.isr_out, 8'h80);
    inta_high();
    inta_low();
    inta_high();
    ocw2_write(8'h67);
    check_val("rot_sp_eoi", bus_if.isr_out, 8'h00);

    // Set priority: LP=3 so IR4 beats IR0
    ocw2_write(8'hC3);
    bus_if.ir = 8'h00;
    tick(1);
    check_val("sp_clr_irr", bus_if.irr_out, 8'h00);
    bus_if.ir = 8'h11;
    tick(2);
    inta_low();
    check_val("sp_highest", bus_if.highest, 8'h10);
    check_val("sp_irr", bus_if.irr_out, 8'h01);
    inta_high();
    inta_low();
    inta_high();
    ocw2_write(8'h64);
    check_val("sp_eoi_isr", bus_if.isr_out, 8'h00);
    bus_if.ir = 8'h00;
    tick(1);
    init_pulse();

    // Spurious acknowledge
    inta_low();
    check_val("spu_highest", bus_if.highest, 8'h80);
    check_val("spu_flag", 8'(bus_if.spurious), 8'h01);
    check_val("spu_isr", bus_if.isr_out, 8'h00);
    inta_high();
    inta_low();
    check_val("spu_ack2_highest", bus_if.highest, 8'h80);
    check_val("spu_ack2_flag", 8'(bus_if.spurious), 8'h01);
    inta_high();
    check_val("spu_end_highest", bus_if.highest, 8'h00);
    check_val("spu_end_flag", 8'(bus_if.spurious), 8'h00);
    check_val("spu_end_isr", bus_if.isr_out, 8'h00);

    // AEOI, level mode, auto-rotate
    bus_if.ltim        = 1'b1;
    bus_if.aeoi        = 1'b1;
    bus_if.auto_rotate = 1'b1;
    bus_if.ir          = 8'h02;
    tick(1);
    check_val("ae_irr", bus_if.irr_out, 8'h02);
    tick(1);
    check_val("ae_int", 8'(bus_if.intr), 8'h01);
    inta_low();
    check_val("ae_highest", bus_if.highest, 8'h02);
    check_val("ae_isr", bus_if.isr_out, 8'h02);
    check_val("ae_irr_ack", bus_if.irr_out, 8'h00);
    inta_high();
    check_val("ae_irr_relatch", bus_if.irr_out, 8'h02);
    check_val("ae_gap_int", 8'(bus_if.intr), 8'h00);
    inta_low();
    inta_high();
    check_val("ae_end_isr", bus_if.isr_out, 8'h00);
    check_val("ae_end_highest", bus_if.highest, 8'h00);
    check_val("ae_end_int", 8'(bus_if.intr), 8'h00);
    tick(1);
    check_val("ae_reint", 8'(bus_if.intr), 8'h01);
    bus_if.ir = 8'h06;
    tick(1);
    check_val("ae_rot_irr", bus_if.irr_out, 8'h06);
    inta_low();
    check_val("ae_rot_highest", bus_if.highest, 8'h04);
    inta_high();
    inta_low();
    inta_high();
    check_val("ae_rot_isr", bus_if.isr_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
